// File: rtl/reg_cmd_ctrl_if.sv
// reg_cmd_ctrl_if: byte link plus register-file port of the command controller
interface reg_cmd_ctrl_if #(parameter int WIDTH = 16, parameter int ADDR = 3);
   logic [7:0]       RxData;
   logic             RxValid;
   logic [7:0]       TxData;
   logic             TxValid;
   logic             TxReady;
   logic [ADDR-1:0]  Address;
   logic             WrEn;
   logic             RdEn;
   logic [WIDTH-1:0] WrData;
   logic [WIDTH-1:0] RdData;
   logic             CmdErr;
   modport master (
      input  RxData, RxValid, TxReady, RdData,
      output TxData, TxValid, Address, WrEn, RdEn, WrData, CmdErr
   );
   modport slave (
      output RxData, RxValid, TxReady, RdData,
      input  TxData, TxValid, Address, WrEn, RdEn, WrData, CmdErr
   );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: decodes AA/BB byte frames into register writes and byte-wise read replies
module reg_cmd_ctrl #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 3
) (
   input logic            CLK,
   input logic            RST,
   reg_cmd_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI
   } state_t;
   state_t           state, nxt;
   logic [WIDTH-1:0] rd_buf;
   logic             bad_cmd;
   assign bad_cmd = state == IDLE && bus.RxValid && bus.RxData != 8'hAA && bus.RxData != 8'hBB;
   always_ff @(posedge CLK)
      if (!RST) begin
         state       <= IDLE;
         bus.Address <= '0;
         bus.WrData  <= '0;
         bus.CmdErr  <= 1'b0;
         rd_buf      <= '0;
      end else begin
         state      <= nxt;
         bus.CmdErr <= bad_cmd;
         if (bus.RxValid && (state == WR_ADDR || state == RD_ADDR)) bus.Address <= bus.RxData[ADDR-1:0];
         if (bus.RxValid && state == WR_LO) bus.WrData[7:0] <= bus.RxData;
         if (bus.RxValid && state == WR_HI) bus.WrData[WIDTH-1:8] <= bus.RxData;
         if (state == RD_WAIT) rd_buf <= bus.RdData;
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !bus.RxValid ? IDLE : bus.RxData == 8'hAA ? WR_ADDR : bus.RxData == 8'hBB ? RD_ADDR : IDLE;
         WR_ADDR: nxt = bus.RxValid ? WR_LO : WR_ADDR;
         WR_LO:   nxt = bus.RxValid ? WR_HI : WR_LO;
         WR_HI:   nxt = bus.RxValid ? WR_EXEC : WR_HI;
         WR_EXEC: nxt = IDLE;
         RD_ADDR: nxt = bus.RxValid ? RD_EXEC : RD_ADDR;
         RD_EXEC: nxt = RD_WAIT;
         RD_WAIT: nxt = TX_LO;
         TX_LO:   nxt = bus.TxReady ? TX_HI : TX_LO;
         TX_HI:   nxt = bus.TxReady ? IDLE : TX_HI;
         default: nxt = IDLE;
      endcase
   end
   // reply bytes come straight from the buffer so they stay stable while stalled
   always_comb begin
      bus.WrEn    = state == WR_EXEC;
      bus.RdEn    = state == RD_EXEC;
      bus.TxValid = state == TX_LO || state == TX_HI;
      bus.TxData  = state == TX_LO ? rd_buf[7:0] : state == TX_HI ? rd_buf[WIDTH-1:8] : 8'h00;
   end
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: vector table, hand-written corner sequences and random frames against a register-file model
module tb_reg_cmd_ctrl;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;
   reg_cmd_ctrl_if #(.WIDTH(16), .ADDR(3)) bus();
   reg_cmd_ctrl #(.WIDTH(16), .ADDR(3)) dut (.CLK(CLK), .RST(RST), .bus(bus.master));
   typedef struct {
      logic [31:0] bytes;
      int          n;
      int          kind;
      logic [2:0]  ea;
      logic [15:0] ed;
   } vec_t;
   vec_t        tbl [12];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] regs [8] = '{default: 16'h0000};
   logic [15:0] mem [8] = '{default: 16'h0000};
   logic [18:0] wr_q [$];
   logic [7:0]  tx_q [$];
   int          rd_cnt = 0, err_cnt = 0, tv_cnt = 0;
   int          rd_base = 0, err_base = 0, tv_base = 0;
   int          rdy_mode = 0;
   logic        stall = 1'b0;
   logic [7:0]  stall_data = 8'h00;
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // register file with one-cycle registered read
   always @(posedge CLK) begin
      if (bus.WrEn) regs[bus.Address] <= bus.WrData;
      if (bus.RdEn) bus.RdData <= regs[bus.Address];
   end
   always @(posedge CLK) begin
      #1;
      bus.TxReady = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
   end
   always @(negedge CLK) begin
      if (bus.WrEn || bus.RdEn) check("wr_rd_exclusive", 32'(bus.WrEn & bus.RdEn), 0);
      if (bus.WrEn) wr_q.push_back({bus.Address, bus.WrData});
      if (bus.RdEn) rd_cnt++;
      if (bus.CmdErr) err_cnt++;
      if (bus.TxValid) tv_cnt++;
      if (stall) check("tx_hold", {bus.TxValid, bus.TxData}, {1'b1, stall_data});
      if (bus.TxValid && bus.TxReady) tx_q.push_back(bus.TxData);
      stall = RST && bus.TxValid && !bus.TxReady;
      stall_data = bus.TxData;
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic send(logic [7:0] b);
      bus.RxData = b;
      bus.RxValid = 1'b1;
      tick();
      bus.RxValid = 1'b0;
   endtask
   task automatic flush();
      wr_q.delete();
      tx_q.delete();
      rd_base = rd_cnt;
      err_base = err_cnt;
      tv_base = tv_cnt;
   endtask
   // kind: 0 write, 1 read (ed = expected register value), 2 unknown command
   task automatic expect_frame(string name, int kind, logic [2:0] ea, logic [15:0] ed, int tv);
      int n = 0;
      if (kind == 1)
         while (tx_q.size() < 2 && n < 300) begin
            tick();
            n++;
         end
      else
         tick();
      check({name, "_wr"}, wr_q.size(), 32'(kind == 0));
      if (kind == 0 && wr_q.size() > 0) check({name, "_wdata"}, wr_q[0], {ea, ed});
      check({name, "_rd"}, rd_cnt - rd_base, 32'(kind == 1));
      check({name, "_err"}, err_cnt - err_base, 32'(kind == 2));
      check({name, "_tx"}, tx_q.size(), kind == 1 ? 2 : 0);
      if (kind == 1 && tx_q.size() == 2) check({name, "_txdata"}, {tx_q[0], tx_q[1]}, {ed[7:0], ed[15:8]});
      if (tv >= 0) check({name, "_tvcycles"}, tv_cnt - tv_base, tv);
      if (kind == 0) mem[ea] = ed;
      flush();
   endtask
   initial begin
      logic [7:0]  a, b;
      logic [15:0] d;
      tbl = '{
         '{32'hAA053412, 4, 0, 3'd5, 16'h1234},
         '{32'hBB050000, 2, 1, 3'd5, 16'h1234},
         '{32'h3C000000, 1, 2, 3'd0, 16'h0000},
         '{32'hAAFDCDAB, 4, 0, 3'd5, 16'hABCD},
         '{32'hBB050000, 2, 1, 3'd5, 16'hABCD},
         '{32'hAA00FF00, 4, 0, 3'd0, 16'h00FF},
         '{32'hBB080000, 2, 1, 3'd0, 16'h00FF},
         '{32'h55000000, 1, 2, 3'd0, 16'h0000},
         '{32'hAA070180, 4, 0, 3'd7, 16'h8001},
         '{32'hBBFF0000, 2, 1, 3'd7, 16'h8001},
         '{32'hBB030000, 2, 1, 3'd3, 16'h0000},
         '{32'hAB000000, 1, 2, 3'd0, 16'h0000}
      };
      bus.RxData = 8'h00;
      bus.RxValid = 1'b0;
      RST = 1'b0;
      repeat (3) tick();
      check("rst_tx", {bus.TxValid, bus.TxData}, 0);
      check("rst_addr", 32'(bus.Address), 0);
      check("rst_wrdata", 32'(bus.WrData), 0);
      check("rst_strobes", {bus.WrEn, bus.RdEn, bus.CmdErr}, 0);
      RST = 1'b1;
      tick();
      flush();
      // write strobe lands exactly one cycle after the data_hi byte
      send(8'hAA);
      send(8'h05);
      send(8'h34);
      bus.RxData = 8'h12;
      bus.RxValid = 1'b1;
      @(negedge CLK);
      check("wr_early", 32'(bus.WrEn), 0);
      @(posedge CLK);
      #1;
      bus.RxValid = 1'b0;
      check("wr_strobe", {bus.WrEn, bus.Address, bus.WrData}, {1'b1, 3'd5, 16'h1234});
      tick();
      check("wr_single", 32'(bus.WrEn), 0);
      mem[5] = 16'h1234;
      flush();
      // stalled reply holds its first byte and drops stray input bytes
      rdy_mode = 2;
      send(8'hBB);
      send(8'h05);
      for (int i = 0; i < 20 && !bus.TxValid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) send(8'hAA);
         else tick();
         check("stall_lo", {bus.TxValid, bus.TxData}, {1'b1, 8'h34});
      end
      rdy_mode = 0;
      expect_frame("stall_read", 1, 3'd5, 16'h1234, -1);
      // reset mid write frame abandons it; the trailing byte is an unknown command
      send(8'hAA);
      send(8'h05);
      send(8'h34);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      check("rst_mid_addr", {bus.Address, bus.WrData}, 0);
      send(8'h12);
      expect_frame("rst_write", 2, 3'd0, 16'h0000, 0);
      // reset during a pending transmit drops the reply
      rdy_mode = 2;
      send(8'hBB);
      send(8'h05);
      for (int i = 0; i < 20 && !bus.TxValid; i++) tick();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      rdy_mode = 0;
      check("rst_tx_drop", {bus.TxValid, bus.TxData}, 0);
      repeat (5) tick();
      check("rst_tx_none", tx_q.size(), 0);
      check("rst_tx_rd", rd_cnt - rd_base, 1);
      flush();
      // a reset pulse between edges must be invisible
      send(8'hAA);
      send(8'h05);
      #1 RST = 1'b0;
      #1 RST = 1'b1;
      send(8'h34);
      send(8'h12);
      expect_frame("rst_glitch", 0, 3'd5, 16'h1234, 0);
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) send(tbl[i].bytes[31 - 8 * k -: 8]);
         expect_frame($sformatf("vec%0d", i), tbl[i].kind, tbl[i].ea, tbl[i].ed, tbl[i].kind == 1 ? 2 : 0);
      end
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         a = 8'($urandom);
         d = 16'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               send(8'hAA);
               send(a);
               send(d[7:0]);
               send(d[15:8]);
               expect_frame("rand_wr", 0, a[2:0], d, -1);
            end
            1: begin
               send(8'hBB);
               send(a);
               expect_frame("rand_rd", 1, a[2:0], mem[a[2:0]], -1);
            end
            default: begin
               b = 8'($urandom);
               if (b == 8'hAA || b == 8'hBB) b = 8'h00;
               send(b);
               expect_frame("rand_err", 2, 3'd0, 16'h0000, -1);
            end
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning register data width; only 16 is supported, as two bytes per word.
REQ-002 SHALL have parameter ADDR, default 3, meaning register address width.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port RxData  input  8  incoming command/data byte.
REQ-006 SHALL have port RxValid  input  1  RxData valid for one cycle.
REQ-007 SHALL have port TxData  output  8  outgoing read-data byte.
REQ-008 SHALL have port TxValid  output  1  TxData valid; held until accepted.
REQ-009 SHALL have port TxReady  input  1  downstream accepts TxData when TxValid&&TxReady.
REQ-010 SHALL have port Address  output  ADDR  register-file address.
REQ-011 SHALL have port WrEn  output  1  register-file write strobe.
REQ-012 SHALL have port RdEn  output  1  register-file read strobe.
REQ-013 SHALL have port WrData  output  WIDTH  register-file write data.
REQ-014 SHALL have port RdData  input  WIDTH  register-file read data, registered there one cycle after RdEn.
REQ-015 SHALL have port CmdErr  output  1  one-cycle pulse on an unknown command byte.

Function
REQ-016 SHALL decode frames from RxValid bytes: write = 0xAA, addr, data_lo, data_hi; read = 0xBB, addr.
REQ-017 SHALL implement the states IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO and TX_HI.
REQ-018 SHALL, in IDLE with RxValid, go to WR_ADDR on 0xAA, go to RD_ADDR on 0xBB, and otherwise pulse CmdErr for 1 cycle and stay in IDLE.
REQ-019 SHALL advance the WR_ADDR, WR_LO, WR_HI and RD_ADDR states only on RxValid, latching the byte; address = RxData[ADDR-1:0], with upper bits ignored.
REQ-020 SHALL latch data_lo into WrData[7:0] and data_hi into WrData[15:8].
REQ-021 SHALL, in WR_EXEC, assert WrEn for exactly 1 cycle with Address/WrData stable, then return to IDLE; a write frame ends 1 cycle after the data_hi byte.
REQ-022 SHALL, in RD_EXEC, assert RdEn for exactly 1 cycle, then go to RD_WAIT.
REQ-023 SHALL, in RD_WAIT, capture RdData into an internal buffer, then go to TX_LO.
REQ-024 SHALL, in TX_LO, drive TxValid=1 with TxData=buf[7:0] until TxReady, then go to TX_HI.
REQ-025 SHALL, in TX_HI, drive TxValid=1 with TxData=buf[15:8] until TxReady, then go to IDLE.
REQ-026 SHALL never assert WrEn and RdEn in the same cycle.
REQ-027 SHALL deassert WrEn and RdEn in every state other than WR_EXEC and RD_EXEC respectively.
REQ-028 SHALL ignore RxValid bytes in the WR_EXEC, RD_EXEC, RD_WAIT, TX_LO and TX_HI states (dropped, no CmdErr).
REQ-029 SHALL hold Address and WrData at their last latched values outside the frame-capture states.
REQ-030 SHALL keep TxData stable while TxValid=1 and TxReady=0.
REQ-031 SHALL let a new command byte be accepted in the cycle the FSM returns to IDLE, with no gap beyond one idle cycle required.

Reset
REQ-032 SHALL, on RST=0 at a rising CLK edge, enter IDLE and clear all outputs: TxData=0, TxValid=0, Address=0, WrEn=0, RdEn=0, WrData=0, CmdErr=0; the read buffer is cleared.
REQ-033 SHALL abandon any partial frame or pending transmit when reset is applied mid-operation, with no WrEn/RdEn emitted afterwards for it.
REQ-034 SHALL take the reset effect only on the clock edge; RST changes between edges have no effect.

Verification
REQ-035 SHALL pass this scenario: write frame AA,05,34,12 -> exactly one WrEn cycle with Address=5, WrData=0x1234, 1 cycle after byte 12.
REQ-036 SHALL pass this scenario: read frame BB,05 with register returning 0x1234 and TxReady=1 -> RdEn 1 cycle, then TxData=34 then 12, TxValid for 2 cycles total.
REQ-037 SHALL pass this scenario: read with TxReady=0 for 5 cycles -> TxValid held, TxData=34 stable; no byte lost after TxReady rises.
REQ-038 SHALL pass this scenario: byte 0x3C in IDLE -> CmdErr=1 for 1 cycle, no WrEn/RdEn, next AA frame works.
REQ-039 SHALL pass this scenario: RST=0 after AA,05,34 -> IDLE, following 12 ignored as an unknown command (CmdErr pulse), no WrEn.
REQ-040 SHALL pass this scenario: address byte 0xFD -> Address=5 on the register-file port.
